// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory with async read and sync write.
// Sub-word stores go through read-modify-write; loads are lane-selected and sign/zero-extended.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wbuf;

  logic              req_err;
  logic [31:0]       word_idx;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] merged;

  assign word_idx       = 32'(req_addr >> 2);
  assign mem_write_data = wbuf;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // A legal halfword always has lane_q[0]=0, so one byte-granular shift serves both sizes.
  assign shamt      = {lane_q, 3'b000};
  assign rd_shifted = mem_read_data >> shamt;

  always_comb begin
    load_ext = mem_read_data;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{signed_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << shamt;
      2'b01:   lane_mask = 32'h0000_FFFF << shamt;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merged = (mem_read_data & ~lane_mask) | ((wbuf << shamt) & lane_mask);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_write  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)             state_next = RESP;
          else if (!req_write)     state_next = LOAD;
          else if (req_size == 2'b10) state_next = WRITE;
          else                     state_next = MERGE;
        end
      end
      LOAD:  state_next = RESP;
      MERGE: state_next = WRITE;
      WRITE: begin
        mem_write  = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset wins over any in-flight handshake or write strobe.
    if (rst) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_address <= '0;
      wbuf        <= '0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q   <= req_size;
            signed_q <= req_signed;
            lane_q   <= req_addr[1:0];
            if (req_err) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end else begin
              mem_address <= word_idx;
              wbuf        <= req_wdata;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_ext;
          resp_err   <= 1'b0;
        end
        MERGE: wbuf <= merged;
        WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios, random traffic against a byte-array
// reference model, held-valid back-to-back requests and reset during a write.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [16];
  logic [7:0]  ref_mem [64];
  logic [32:0] exp_q [$];

  int          tests = 0;
  int          fails = 0;
  int          write_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  // 16-word memory; upper index bits wrap.
  assign mem_read_data = mem[mem_address[3:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[3:0]] <= mem_write_data;

  always @(negedge clk) begin
    if (mem_write) begin
      write_count  = write_count + 1;
      last_wr_addr = mem_address;
      last_wr_data = mem_write_data;
      tests = tests + 1;
      assert (!req_ready && !resp_valid)
      else begin
        fails = fails + 1;
        $error("FAIL write_overlap ready=%b resp_valid=%b expected 0 0", req_ready, resp_valid);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests = tests + 1;
    assert (observed === expected)
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model on a byte array: returns {err, rdata} and applies stores.
  function automatic logic [32:0] model_op(input logic w, input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] wd);
    int          nb;
    int          base;
    logic [31:0] v;
    logic [63:0] m;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (sz == 2'b11 || (a % nb) != 0) return {1'b1, 32'h0};
    base = int'(a[5:0]);
    if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[base + i] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
    m = (64'd1 << (8 * nb)) - 64'd1;
    if (sg && v[8*nb-1]) v = v | ~m[31:0];
    return {1'b0, v};
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [32:0] e;
    int          exp_lat;
    int          lat;
    int          n;
    int          wc0;
    e       = model_op(w, sz, sg, a, wd);
    exp_lat = e[32] ? 1 : (w && sz != 2'b10) ? 3 : 2;
    @(negedge clk);
    drive(w, sz, sg, a, wd);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    wc0 = write_count;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check32({tag, "_latency"}, lat, exp_lat);
    check32({tag, "_rdata"}, resp_rdata, e[31:0]);
    check32({tag, "_err"}, {31'b0, resp_err}, {31'b0, e[32]});
    check32({tag, "_writes"}, write_count - wc0, (w && !e[32]) ? 32'd1 : 32'd0);
    @(negedge clk);
    check32({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic        w5 [6];
    logic [1:0]  s5 [6];
    logic        g5 [6];
    logic [31:0] a5 [6];
    logic [31:0] d5 [6];
    logic [32:0] e;
    logic [31:0] rw;
    logic        rw_w;
    logic [1:0]  rw_s;
    logic [31:0] rw_a;
    int          n_acc, n_resp, cyc, wc0, exp_writes, n;
    bit          adv;

    for (int i = 0; i < 16; i++) begin
      rw = $urandom;
      mem[i] = rw;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = rw[8*b +: 8];
    end

    // Reset values
    rst = 1'b1;
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("rst_ready", {31'b0, req_ready}, 32'd0);
    check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check32("rst_rdata", resp_rdata, 32'd0);
    check32("rst_err", {31'b0, resp_err}, 32'd0);
    check32("rst_mem_address", mem_address, 32'd0);
    check32("rst_mem_wdata", mem_write_data, 32'd0);
    check32("rst_mem_write", {31'b0, mem_write}, 32'd0);
    rst = 1'b0;

    // Word store / load
    do_req("t1_sw", 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
    check32("t1_wr_addr", last_wr_addr, 32'd2);
    check32("t1_wr_data", last_wr_data, 32'hDEADBEEF);
    check32("t1_mem2", mem[2], 32'hDEADBEEF);
    do_req("t1_lw", 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    check32("t1_lw_const", resp_rdata, 32'hDEADBEEF);

    // Byte store and loads
    do_req("t2_sb", 1'b1, 2'b00, 1'b0, 32'h09, 32'h000000A5);
    check32("t2_mem2", mem[2], 32'hDEADA5EF);
    do_req("t2_lbs", 1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
    check32("t2_lbs_const", resp_rdata, 32'hFFFFFFA5);
    do_req("t2_lbu", 1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    check32("t2_lbu_const", resp_rdata, 32'h000000A5);

    // Half store and loads
    do_req("t3_sh", 1'b1, 2'b01, 1'b0, 32'h0A, 32'h00001234);
    check32("t3_mem2", mem[2], 32'h1234A5EF);
    do_req("t3_lhs_hi", 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
    check32("t3_lhs_hi_const", resp_rdata, 32'h00001234);
    do_req("t3_lhs_lo", 1'b0, 2'b01, 1'b1, 32'h08, 32'h0);
    check32("t3_lhs_lo_const", resp_rdata, 32'hFFFFA5EF);

    // Errors
    do_req("t4_lw_mis", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    do_req("t4_sh_mis", 1'b1, 2'b01, 1'b0, 32'h03, 32'h00001111);
    do_req("t4_ill", 1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    check32("t4_mem0", mem[0], ref_word(0));
    check32("t4_mem1", mem[1], ref_word(1));

    // Random traffic, half the addresses forced aligned
    for (int i = 0; i < 40; i++) begin
      rw_w = 1'($urandom_range(0, 1));
      rw_s = 2'($urandom_range(0, 3));
      rw_a = $urandom;
      if ($urandom_range(0, 1) == 1) rw_a[1:0] = 2'b00;
      do_req("rnd", rw_w, rw_s, 1'($urandom_range(0, 1)), rw_a, $urandom);
    end

    // Held req_valid over six mixed requests
    w5[0] = 1'b1; s5[0] = 2'b00; g5[0] = 1'b0; a5[0] = 32'h11; d5[0] = 32'h5A;
    w5[1] = 1'b0; s5[1] = 2'b00; g5[1] = 1'b1; a5[1] = 32'h11; d5[1] = 32'h0;
    w5[2] = 1'b1; s5[2] = 2'b10; g5[2] = 1'b0; a5[2] = 32'h14; d5[2] = $urandom;
    w5[3] = 1'b0; s5[3] = 2'b01; g5[3] = 1'b0; a5[3] = 32'h16; d5[3] = 32'h0;
    w5[4] = 1'b1; s5[4] = 2'b10; g5[4] = 1'b0; a5[4] = 32'h15; d5[4] = $urandom;
    w5[5] = 1'b1; s5[5] = 2'b01; g5[5] = 1'b0; a5[5] = 32'h12; d5[5] = $urandom;
    wc0 = write_count;
    exp_writes = 0;
    n_acc = 0;
    n_resp = 0;
    cyc = 0;
    adv = 1'b0;
    @(negedge clk);
    drive(w5[0], s5[0], g5[0], a5[0], d5[0]);
    req_valid = 1'b1;
    while ((n_acc < 6 || n_resp < 6) && cyc < 200) begin
      if (resp_valid) begin
        n_resp++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 32'hBAD0BAD0};
        check32("t5_rdata", resp_rdata, e[31:0]);
        check32("t5_err", {31'b0, resp_err}, {31'b0, e[32]});
      end
      if (adv) begin
        adv = 1'b0;
        if (n_acc < 6) drive(w5[n_acc], s5[n_acc], g5[n_acc], a5[n_acc], d5[n_acc]);
        else           req_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        check32("t5_ready_idle", n_resp, n_acc);
        e = model_op(req_write, req_size, req_signed, req_addr, req_wdata);
        exp_q.push_back(e);
        if (req_write && !e[32]) exp_writes++;
        n_acc++;
        adv = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    repeat (3) begin
      check32("t5_no_extra_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check32("t5_accepts", n_acc, 32'd6);
    check32("t5_resps", n_resp, 32'd6);
    check32("t5_writes", write_count - wc0, exp_writes);

    // Reset while in WRITE
    drive(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("t6_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check32("t6_pre_rst_write", {31'b0, mem_write}, 32'd1);
    wc0 = write_count;
    rst = 1'b1;
    #1;
    check32("t6_rst_no_write", {31'b0, mem_write}, 32'd0);
    check32("t6_rst_no_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check32("t6_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check32("t6_ready_after", {31'b0, req_ready}, 32'd1);
    check32("t6_rdata", resp_rdata, 32'd0);
    check32("t6_err", {31'b0, resp_err}, 32'd0);
    check32("t6_mem_address", mem_address, 32'd0);
    check32("t6_mem_wdata", mem_write_data, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check32("t6_quiet_resp", {31'b0, resp_valid}, 32'd0);
    end
    check32("t6_writes", write_count - wc0, 32'd0);
    check32("t6_mem8", mem[8], ref_word(8));

    for (int i = 0; i < 16; i++) check32("final_mem", mem[i], ref_word(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
